mul_sequencer: RTL
==================

// Module: mul_sequencer
// PURPOSE
//  Iterative RV32M multiply controller. It sequences one shared 32-bit adder through 32 shift-add
//  steps to form a 64-bit product, then returns the low or high word.
//  Sits beside the ALU in the execute stage. The core stalls on req_ready/resp_valid.
//  Covers MUL, MULH, MULHSU and MULHU. Division is out of scope.
// PARAMETERS
//  XLEN         32  operand width; only 32 is supported (matches the shared adder)
//  ZERO_BYPASS  1   1: when either operand is 0, skip iteration and respond 1 cycle after accept
// PORTS
//  clk         in   1     rising-edge clock
//  reset       in   1     synchronous, active-high; one clock, no other clock domain
//  flush       in   1     synchronous abort of any in-flight op (pipeline kill)
//  req_valid   in   1     request present
//  req_ready   out  1     sequencer can accept (high only in IDLE)
//  req_op      in   2     mul_pkg::mul_op_e: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//  req_a       in   32    rs1 (multiplicand)
//  req_b       in   32    rs2 (multiplier)
//  resp_valid  out  1     result held valid (high only in DONE)
//  resp_ready  in   1     consumer takes result
//  resp_data   out  32    MUL: product[31:0]; all others: product[63:32]
//  busy        out  1     high in CALC or FIX (stall hint for hazard unit)
// BEHAVIOUR
//  Reset values: state=IDLE; req_ready=1; resp_valid=0; busy=0; resp_data=0; counter=0.
//  FSM states: IDLE, CALC, FIX, DONE.
//   IDLE, req_valid&req_ready:
//    - latch |a| and |b|, op, and neg = sign_a ^ sign_b
//    - signedness: MULH a,b signed; MULHSU a signed only; MUL/MULHU unsigned
//    - MUL low word is identical either way, so MUL is treated unsigned
//    - clear acc_hi and cnt
//    - next state is CALC, or DONE when ZERO_BYPASS and (a==0 | b==0); result 0
//   CALC: one step per cycle over {acc_hi[31:0], mplr[31:0]}.
//    - sum = mplr[0] ? acc_hi + mcand : acc_hi, formed through the adder instance
//    - carry = (x[31]&y[31]) | ((x[31]|y[31]) & ~sum[31])
//    - next {acc_hi,mplr} = {carry, sum, mplr[31:1]}
//    - cnt increments; after step 32 (cnt==31) go to FIX
//   FIX:
//    - if neg, product = ~product + 1 (64-bit two's complement; reuse the adder for the low word
//      with a carry into the high word)
//    - select and register resp_data; go to DONE
//   DONE: resp_valid=1 and resp_data stable until resp_valid&resp_ready; then IDLE.
//  Latency: resp_valid rises 34 cycles after the accept edge (33 with ZERO_BYPASS=0 shortcut
//   disabled is N/A; bypass gives 1 cycle). Throughput: one op per 35 cycles minimum.
//  No new request is accepted in the same cycle a response is consumed; req_ready rises the next cycle.
//  flush, any state: next state=IDLE, resp_valid=0, result discarded. reset has priority over flush.
//  Boundary cases:
//   - MULH 0x80000000*0x80000000: |a| = 0x80000000, taken as unsigned; no overflow special case
//   - operand 0xFFFFFFFF unsigned with ZERO_BYPASS: runs the full 32 steps
//  resp_data, req_* inputs: ignored outside IDLE. Changing inputs mid-op has no effect.
// STRUCTURE
//  mul_pkg:
//   - mul_op_e (2-bit enum)
//   - mul_state_e {IDLE, CALC, FIX, DONE}
//   - localparam MUL_STEPS = 32
//  Sub-module: the existing 32-bit adder, one instance, shared by CALC steps and the FIX negation.
//   Carry-out is derived externally per the formula above.
//  FSM, counter, operand regs and output regs live in mul_sequencer.
// TESTING
//  MUL 7*6 -> resp_data=0x0000002A; resp_valid rises 34 cycles after accept.
//  MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MUL same operands -> 0x00000001.
//  MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000.
//  MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
//  MULH 0x80000000*0x80000000 -> 0x40000000.
//  ZERO_BYPASS: MUL 0*0x1234 -> resp_data=0, resp_valid 1 cycle after accept.
//  Backpressure: resp_ready=0 for 5 cycles -> resp_data held, req_ready=0 throughout.
//  flush at cycle 10 of CALC -> IDLE next cycle, no resp_valid; next op MUL 3*5 -> 0x0F.
//  reset mid-CALC -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative RV32M multiply sequencer.
package mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mul_state_e;

  localparam int MUL_STEPS = 32;

  // Magnitude of a 32-bit operand; 0x80000000 stays 0x80000000 and is then read as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_neg);
    return is_neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_sequencer_adder.sv
// Plain 32-bit adder with carry-in, shared by the shift-add steps and the final negation.
module mul_sequencer_adder #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  input  logic            cin,
  output logic [XLEN-1:0] sum
);

  assign sum = x + y + XLEN'(cin);

endmodule

// File: rtl/mul_sequencer.sv
// Iterative RV32M multiplier: 32 shift-add steps through one shared adder, then sign fix-up.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// CALC  | one shift-add step per cycle over {acc_hi, mplr}
// FIX   | optional two's complement of the 64-bit product, select word
// DONE  | result held on resp_data until consumed
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  localparam int CNT_W = $clog2(MUL_STEPS);

  mul_state_e      state_q, state_d;
  mul_op_e         op_in, op_q;
  logic            neg_q;
  logic [XLEN-1:0] mcand_q, mplr_q, acc_hi_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] resp_data_q;

  logic            a_signed, b_signed, a_neg, b_neg, zero_hit, accept;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] add_x, add_y, add_sum;
  logic            add_cin, add_carry;
  logic [XLEN-1:0] fix_lo, fix_hi;

  // MUL low word is sign-independent, so only MULH/MULHSU treat operands as signed.
  always_comb begin
    op_in    = mul_op_e'(req_op);
    a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU);
    b_signed = (op_in == OP_MULH);
    a_neg    = a_signed && req_a[XLEN-1];
    b_neg    = b_signed && req_b[XLEN-1];
    a_mag    = mag32(req_a, a_neg);
    b_mag    = mag32(req_b, b_neg);
    zero_hit = (req_a == '0) || (req_b == '0);
    accept   = (state_q == IDLE) && req_valid && !flush;
  end

  // FIX negates the low word as ~lo + 1; otherwise the adder performs a shift-add step.
  always_comb begin
    if (state_q == FIX) begin
      add_x   = ~mplr_q;
      add_y   = '0;
      add_cin = 1'b1;
    end else begin
      add_x   = acc_hi_q;
      add_y   = mplr_q[0] ? mcand_q : '0;
      add_cin = 1'b0;
    end
  end

  mul_sequencer_adder #(.XLEN(XLEN)) u_adder (
    .x   (add_x),
    .y   (add_y),
    .cin (add_cin),
    .sum (add_sum)
  );

  assign add_carry = (add_x[XLEN-1] & add_y[XLEN-1]) |
                     ((add_x[XLEN-1] | add_y[XLEN-1]) & ~add_sum[XLEN-1]);

  assign fix_lo = neg_q ? add_sum : mplr_q;
  assign fix_hi = neg_q ? (~acc_hi_q + XLEN'(add_carry)) : acc_hi_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = (ZERO_BYPASS && zero_hit) ? DONE : CALC;
      CALC: if (cnt_q == CNT_W'(MUL_STEPS - 1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= OP_MUL;
      neg_q       <= 1'b0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      acc_hi_q    <= '0;
      cnt_q       <= '0;
      resp_data_q <= '0;
    end else if (accept) begin
      op_q     <= op_in;
      neg_q    <= a_neg ^ b_neg;
      mcand_q  <= a_mag;
      mplr_q   <= b_mag;
      acc_hi_q <= '0;
      cnt_q    <= '0;
      if (ZERO_BYPASS && zero_hit) resp_data_q <= '0;
    end else if (!flush && state_q == CALC) begin
      {acc_hi_q, mplr_q} <= {add_carry, add_sum, mplr_q[XLEN-1:1]};
      cnt_q              <= cnt_q + CNT_W'(1);
    end else if (!flush && state_q == FIX) begin
      resp_data_q <= (op_q == OP_MUL) ? fix_lo : fix_hi;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q == CALC) || (state_q == FIX);
  assign resp_data  = resp_data_q;

endmodule
